fp_retire_stage: RTL and testbench

FP_RETIRE_STAGE -- requirements
Module: fp_retire_stage

---
 rtl/fp_retire_stage.sv | 135 +++++++++++++
 tb/tb_fp_retire_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_retire_stage.sv
// Retire stage for FP results: buffers rounded results, NaN-boxes singles,
// accumulates sticky exception flags and raises a trap on enabled exceptions.
module fp_retire_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_fp,
  input  logic [4:0]  in_ieee,
  input  logic        in_db,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_fp,
  output logic [4:0]  out_flags,
  output logic        out_db,
  input  logic [4:0]  trap_en,
  input  logic        flags_wr,
  input  logic [4:0]  flags_wdata,
  input  logic        flags_clr,
  output logic [4:0]  sticky_flags,
  output logic        trap,
  output logic [4:0]  trap_cause,
  input  logic        trap_ack
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [63:0]     fp_q [DEPTH];
  logic [4:0]      fl_q [DEPTH];
  logic            db_q [DEPTH];
  logic [AW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  logic            alive_q;
  logic [4:0]      sticky_q, sticky_d;
  logic [4:0]      cause_q;
  logic            push, retire, trap_hit;
  logic [63:0]     boxed_fp;

  assign push     = in_valid & in_ready;
  assign retire   = out_valid & out_ready;
  assign trap_hit = retire & (|(out_flags & trap_en));
  assign boxed_fp = in_db ? in_fp : {32'hFFFF_FFFF, in_fp[31:0]};

  // Storage is reset too, so the head outputs read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fp_q[i] <= '0;
        fl_q[i] <= '0;
        db_q[i] <= 1'b0;
      end
    end else if (push) begin
      fp_q[tail_q] <= boxed_fp;
      fl_q[tail_q] <= in_ieee;
      db_q[tail_q] <= in_db;
    end
  end

  assign out_fp    = fp_q[head_q];
  assign out_flags = fl_q[head_q];
  assign out_db    = db_q[head_q];

  always_comb begin
    count_d = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      count_q <= count_d;
      if (push)   tail_q <= tail_q + AW'(1);
      if (retire) head_q <= head_q + AW'(1);
    end
  end

  // A retiring result's flags are OR-ed in after any software write or clear.
  always_comb begin
    sticky_d = flags_wr ? flags_wdata : (flags_clr ? 5'd0 : sticky_q);
    if (retire) sticky_d = sticky_d | out_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      cause_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (trap_hit)
        cause_q <= out_flags & trap_en;
      else if (state_q == ST_TRAP && trap_ack)
        cause_q <= '0;
    end
  end

  assign sticky_flags = sticky_q;
  assign trap_cause   = cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (trap_hit) state_d = ST_TRAP;
      ST_TRAP: if (trap_ack) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // in_ready stays low until the first edge after reset release.
  always_comb begin
    trap      = (state_q == ST_TRAP);
    in_ready  = (state_q == ST_RUN) && alive_q && (count_q < CW'(DEPTH));
    out_valid = (state_q == ST_RUN) && (count_q != '0);
  end

endmodule

// File: tb/tb_fp_retire_stage.sv
// Bench for fp_retire_stage: directed vector table, random traffic against a
// queue-based reference model, and reset corner sequences.
module tb_fp_retire_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_fp;
  logic [4:0]  in_ieee;
  logic        in_db;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_fp;
  logic [4:0]  out_flags;
  logic        out_db;
  logic [4:0]  trap_en;
  logic        flags_wr;
  logic [4:0]  flags_wdata;
  logic        flags_clr;
  logic [4:0]  sticky_flags;
  logic        trap;
  logic [4:0]  trap_cause;
  logic        trap_ack;

  fp_retire_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
    .in_ieee(in_ieee), .in_db(in_db),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
    .out_flags(out_flags), .out_db(out_db),
    .trap_en(trap_en), .flags_wr(flags_wr), .flags_wdata(flags_wdata),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags),
    .trap(trap), .trap_cause(trap_cause), .trap_ack(trap_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] fp;
    logic [4:0]  fl;
    logic        db;
  } entry_t;

  // Reference model state
  entry_t      mq[$];
  logic        m_trap;
  logic [4:0]  m_cause;
  logic [4:0]  m_sticky;
  logic        m_alive;

  typedef struct {
    logic        iv;
    logic [63:0] fp;
    logic [4:0]  ieee;
    logic        db;
    logic        ordy;
    logic [4:0]  ten;
    logic        fwr;
    logic [4:0]  fwd;
    logic        fclr;
    logic        ack;
    logic        e_ov;
    logic [63:0] e_fp;
    logic        e_chk;
    logic [4:0]  e_sticky;
    logic        e_trap;
    logic [4:0]  e_cause;
    logic        e_ir;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [63:0] fp, input logic [4:0] ieee,
                       input logic db, input logic ordy, input logic [4:0] ten,
                       input logic fwr, input logic [4:0] fwd, input logic fclr,
                       input logic ack);
    in_valid = iv; in_fp = fp; in_ieee = ieee; in_db = db; out_ready = ordy;
    trap_en = ten; flags_wr = fwr; flags_wdata = fwd; flags_clr = fclr; trap_ack = ack;
  endtask

  task automatic model_reset();
    mq.delete();
    m_trap = 1'b0; m_cause = '0; m_sticky = '0; m_alive = 1'b0;
  endtask

  // One clock: predict from model state and current inputs, then compare.
  task automatic tick(input string tag);
    bit         ir, ov, push, pop;
    logic [4:0] hf;
    entry_t     e;
    ir   = !m_trap && m_alive && (mq.size() < DEPTH);
    ov   = !m_trap && (mq.size() != 0);
    push = in_valid && ir;
    pop  = ov && out_ready;
    hf   = pop ? mq[0].fl : 5'd0;
    e.fp = in_db ? in_fp : {32'hFFFF_FFFF, in_fp[31:0]};
    e.fl = in_ieee;
    e.db = in_db;
    @(posedge clk);
    m_sticky = (flags_wr ? flags_wdata : (flags_clr ? 5'd0 : m_sticky)) | hf;
    if (!m_trap && pop && ((hf & trap_en) != 0)) begin
      m_trap = 1'b1; m_cause = hf & trap_en;
    end else if (m_trap && trap_ack) begin
      m_trap = 1'b0; m_cause = '0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    m_alive = 1'b1;
    #1;
    ir = !m_trap && m_alive && (mq.size() < DEPTH);
    ov = !m_trap && (mq.size() != 0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'(ir));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, " sticky"}, 64'(sticky_flags), 64'(m_sticky));
    chk({tag, " trap"}, 64'(trap), 64'(m_trap));
    chk({tag, " trap_cause"}, 64'(trap_cause), 64'(m_cause));
    if (ov) begin
      chk({tag, " out_fp"}, out_fp, mq[0].fp);
      chk({tag, " out_flags"}, 64'(out_flags), 64'(mq[0].fl));
      chk({tag, " out_db"}, 64'(out_db), 64'(mq[0].db));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " sticky"}, 64'(sticky_flags), 64'd0);
    chk({tag, " trap"}, 64'(trap), 64'd0);
    chk({tag, " trap_cause"}, 64'(trap_cause), 64'd0);
    chk({tag, " out_fp"}, out_fp, 64'd0);
    chk({tag, " out_flags"}, 64'(out_flags), 64'd0);
    chk({tag, " out_db"}, 64'(out_db), 64'd0);
  endtask

  initial begin
    // iv fp ieee db ordy ten fwr fwd fclr ack | ov e_fp chk sticky trap cause ir
    vecs[0]  = '{1, 64'h3FF0_0000_0000_0000, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h3FF0_0000_0000_0000, 1, 5'b00000, 0, 5'b00000, 1};
    vecs[1]  = '{1, 64'h0000_0000_3F80_0000, 5'b00000, 0, 1, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'hFFFF_FFFF_3F80_0000, 1, 5'b00000, 0, 5'b00000, 1};
    vecs[2]  = '{0, 64'h0, 5'b00000, 0, 1, 5'b00000, 0, 5'b00000, 0, 0,
                 0, 64'h0, 0, 5'b00000, 0, 5'b00000, 1};
    vecs[3]  = '{1, 64'h1111, 5'b00000, 1, 0, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h1111, 1, 5'b00000, 0, 5'b00000, 1};
    vecs[4]  = '{1, 64'h2222, 5'b00000, 1, 0, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h1111, 1, 5'b00000, 0, 5'b00000, 0};
    vecs[5]  = '{1, 64'h3333, 5'b00000, 1, 0, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h1111, 1, 5'b00000, 0, 5'b00000, 0};
    vecs[6]  = '{1, 64'h3333, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h2222, 1, 5'b00000, 0, 5'b00000, 1};
    vecs[7]  = '{1, 64'h3333, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h3333, 1, 5'b00000, 0, 5'b00000, 1};
    vecs[8]  = '{0, 64'h0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 0,
                 0, 64'h0, 0, 5'b00000, 0, 5'b00000, 1};
    vecs[9]  = '{1, 64'h4444, 5'b10100, 1, 0, 5'b00100, 0, 5'b00000, 0, 0,
                 1, 64'h4444, 1, 5'b00000, 0, 5'b00000, 1};
    vecs[10] = '{0, 64'h0, 5'b00000, 1, 1, 5'b00100, 0, 5'b00000, 0, 0,
                 0, 64'h0, 0, 5'b10100, 1, 5'b00100, 0};
    vecs[11] = '{0, 64'h0, 5'b00000, 1, 1, 5'b11111, 0, 5'b00000, 1, 0,
                 0, 64'h0, 0, 5'b00000, 1, 5'b00100, 0};
    vecs[12] = '{0, 64'h0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 1,
                 0, 64'h0, 0, 5'b00000, 0, 5'b00000, 1};
    vecs[13] = '{0, 64'h0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 0, 1,
                 0, 64'h0, 0, 5'b00000, 0, 5'b00000, 1};
    vecs[14] = '{0, 64'h0, 5'b00000, 1, 1, 5'b00000, 1, 5'b00011, 0, 0,
                 0, 64'h0, 0, 5'b00011, 0, 5'b00000, 1};
    vecs[15] = '{1, 64'h5555, 5'b10000, 1, 0, 5'b00000, 0, 5'b00000, 0, 0,
                 1, 64'h5555, 1, 5'b00011, 0, 5'b00000, 1};
    vecs[16] = '{0, 64'h0, 5'b00000, 1, 1, 5'b00000, 0, 5'b00000, 1, 0,
                 0, 64'h0, 0, 5'b10000, 0, 5'b00000, 1};
    vecs[17] = '{0, 64'h0, 5'b00000, 1, 1, 5'b00000, 1, 5'b01000, 1, 0,
                 0, 64'h0, 0, 5'b01000, 0, 5'b00000, 1};

    drive(0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    @(posedge clk); #1;
    check_zero("reset_held");
    #3 rst_n = 1'b1;
    tick("release");

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].iv, vecs[i].fp, vecs[i].ieee, vecs[i].db, vecs[i].ordy,
            vecs[i].ten, vecs[i].fwr, vecs[i].fwd, vecs[i].fclr, vecs[i].ack);
      tick(tag);
      chk({tag, " tbl out_valid"}, 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_chk) chk({tag, " tbl out_fp"}, out_fp, vecs[i].e_fp);
      chk({tag, " tbl sticky"}, 64'(sticky_flags), 64'(vecs[i].e_sticky));
      chk({tag, " tbl trap"}, 64'(trap), 64'(vecs[i].e_trap));
      chk({tag, " tbl trap_cause"}, 64'(trap_cause), 64'(vecs[i].e_cause));
      chk({tag, " tbl in_ready"}, 64'(in_ready), 64'(vecs[i].e_ir));
    end

    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0,
            ($urandom_range(0, 15) == 0), 5'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      tick($sformatf("rnd%0d", c));
    end

    // Drain to an empty RUN state, then build a trap with data still buffered.
    drive(0, 64'h0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) tick($sformatf("drain%0d", c));
    drive(1, 64'hAAAA, 5'b00001, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick("fill0");
    drive(1, 64'hBBBB, 5'b00000, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick("fill1");
    drive(0, 64'h0, 5'd0, 1'b1, 1'b1, 5'b00001, 1'b0, 5'd0, 1'b0, 1'b0);
    tick("trap_set");
    chk("trap_set trap", 64'(trap), 64'd1);
    chk("trap_set cause", 64'(trap_cause), 64'd1);

    drive(1, 64'hCCCC, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1 check_zero("midreset_async");
    @(posedge clk); #1;
    check_zero("midreset_held");
    #3 rst_n = 1'b1;
    drive(0, 64'h0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick("midreset_release");
    tick("midreset_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
